// File: rtl/ysyx_040750_clint_pkg.sv
// rtl/ysyx_040750_clint_pkg.sv - CLINT register offsets, decode type and byte-merge helper
package ysyx_040750_clint_pkg;

  localparam logic [31:0] CLINT_BASE_ADDR = 32'h0200_0000;

  localparam logic [31:0] MSIP_OFF     = 32'h0000_0000;
  localparam logic [31:0] MTIMECMP_OFF = 32'h0000_4000;
  localparam logic [31:0] MTIME_OFF    = 32'h0000_BFF8;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_MSIP,
    REG_MTIMECMP,
    REG_MTIME
  } clint_reg_e;

  // Replace only the bytes whose strobe bit is set.
  function automatic logic [63:0] byte_merge(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    res = old_val;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) begin
        res[i*8 +: 8] = new_val[i*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ysyx_040750_clint_timer.sv
// rtl/ysyx_040750_clint_timer.sv - prescaler and 64-bit mtime counter with strobed write port
module ysyx_040750_clint_timer
  import ysyx_040750_clint_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        I_sys_clk,
  input  logic        I_rst,
  input  logic        wr_en,
  input  logic [63:0] wr_data,
  input  logic [7:0]  wr_strb,
  output logic [63:0] mtime,
  output logic [63:0] mtime_next
);

  localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

  logic [15:0] prescaler;
  logic [15:0] prescaler_next;
  logic        tick;

  // Next prescaler/mtime; a software write beats the tick and the prescaler keeps running.
  always_comb begin
    tick           = (prescaler == PRESC_LAST);
    prescaler_next = tick ? 16'd0 : prescaler + 16'd1;
    mtime_next     = mtime;
    if (wr_en) begin
      mtime_next = byte_merge(mtime, wr_data, wr_strb);
    end else if (tick) begin
      mtime_next = mtime + 64'd1;
    end
  end

  // Counter state registers.
  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      prescaler <= 16'd0;
      mtime     <= 64'd0;
    end else begin
      prescaler <= prescaler_next;
      mtime     <= mtime_next;
    end
  end

endmodule

// File: rtl/ysyx_040750_clint.sv
// rtl/ysyx_040750_clint.sv - core-local interruptor: MMIO decode, mtimecmp, msip, timer compare
module ysyx_040750_clint
  import ysyx_040750_clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = CLINT_BASE_ADDR,
  parameter int          TICK_DIV     = 1,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        I_sys_clk,
  input  logic        I_rst,
  input  logic        I_req_valid,
  output logic        O_req_ready,
  input  logic        I_req_wen,
  input  logic [31:0] I_req_addr,
  input  logic [63:0] I_req_wdata,
  input  logic [7:0]  I_req_wstrb,
  output logic        O_rsp_valid,
  input  logic        I_rsp_ready,
  output logic [63:0] O_rsp_rdata,
  output logic        O_rsp_err,
  output logic        O_mtip,
  output logic        O_msip
);

  logic [31:0] offset;
  clint_reg_e  sel;
  logic        accept;
  logic        wr_ok;
  logic        mtime_wr;
  logic [63:0] mtime;
  logic [63:0] mtime_next;
  logic [63:0] mtimecmp;
  logic [63:0] mtimecmp_next;
  logic        msip;
  logic        msip_next;
  logic [63:0] rd_data;

  // Single response slot: a new request may enter when the slot is empty or draining.
  assign O_req_ready = ~O_rsp_valid | I_rsp_ready;
  assign accept      = I_req_valid & O_req_ready;
  assign O_msip      = msip;

  // Address decode, register write merge and read mux.
  always_comb begin
    offset = I_req_addr - BASE_ADDR;
    sel    = REG_NONE;
    if (I_req_addr[2:0] == 3'b000) begin
      case (offset)
        MSIP_OFF:     sel = REG_MSIP;
        MTIMECMP_OFF: sel = REG_MTIMECMP;
        MTIME_OFF:    sel = REG_MTIME;
        default:      sel = REG_NONE;
      endcase
    end

    wr_ok    = accept & I_req_wen & (sel != REG_NONE);
    mtime_wr = wr_ok & (sel == REG_MTIME) & (|I_req_wstrb);

    mtimecmp_next = mtimecmp;
    if (wr_ok && sel == REG_MTIMECMP) begin
      mtimecmp_next = byte_merge(mtimecmp, I_req_wdata, I_req_wstrb);
    end

    msip_next = msip;
    if (wr_ok && sel == REG_MSIP && I_req_wstrb[0]) begin
      msip_next = I_req_wdata[0];
    end

    rd_data = 64'd0;
    if (!I_req_wen) begin
      case (sel)
        REG_MSIP:     rd_data = {63'd0, msip};
        REG_MTIMECMP: rd_data = mtimecmp;
        REG_MTIME:    rd_data = mtime;
        default:      rd_data = 64'd0;
      endcase
    end
  end

  ysyx_040750_clint_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .I_sys_clk  (I_sys_clk),
    .I_rst      (I_rst),
    .wr_en      (mtime_wr),
    .wr_data    (I_req_wdata),
    .wr_strb    (I_req_wstrb),
    .mtime      (mtime),
    .mtime_next (mtime_next)
  );

  // Register state and the timer-pending level computed from post-edge values.
  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      mtimecmp <= MTIMECMP_RST;
      msip     <= 1'b0;
      O_mtip   <= 1'b0;
    end else begin
      mtimecmp <= mtimecmp_next;
      msip     <= msip_next;
      O_mtip   <= (mtime_next >= mtimecmp_next);
    end
  end

  // Response register: loads on accept, clears once the LSU takes it.
  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      O_rsp_valid <= 1'b0;
      O_rsp_rdata <= 64'd0;
      O_rsp_err   <= 1'b0;
    end else if (accept) begin
      O_rsp_valid <= 1'b1;
      O_rsp_rdata <= rd_data;
      O_rsp_err   <= (sel == REG_NONE);
    end else if (I_rsp_ready) begin
      O_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_040750_clint.sv
// tb/tb_ysyx_040750_clint.sv - scoreboard bench for the CLINT with TICK_DIV 1 and 4 instances
module tb_ysyx_040750_clint;

  localparam logic [31:0] BASE    = 32'h0200_0000;
  localparam logic [31:0] A_MSIP  = BASE;
  localparam logic [31:0] A_CMP   = BASE + 32'h4000;
  localparam logic [31:0] A_MTIME = BASE + 32'hBFF8;
  localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_wen = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [63:0] req_wdata = 64'd0;
  logic [7:0]  req_wstrb = 8'd0;
  logic        rsp_ready = 1'b1;

  logic        ready_a, rsp_valid_a, err_a, mtip_a, msip_a;
  logic        ready_b, rsp_valid_b, err_b, mtip_b, msip_b;
  logic [63:0] rdata_a, rdata_b;

  always #5 clk = ~clk;

  ysyx_040750_clint #(.TICK_DIV(1)) u_dut_a (
    .I_sys_clk(clk), .I_rst(rst), .I_req_valid(req_valid), .O_req_ready(ready_a),
    .I_req_wen(req_wen), .I_req_addr(req_addr), .I_req_wdata(req_wdata),
    .I_req_wstrb(req_wstrb), .O_rsp_valid(rsp_valid_a), .I_rsp_ready(rsp_ready),
    .O_rsp_rdata(rdata_a), .O_rsp_err(err_a), .O_mtip(mtip_a), .O_msip(msip_a));

  ysyx_040750_clint #(.TICK_DIV(4)) u_dut_b (
    .I_sys_clk(clk), .I_rst(rst), .I_req_valid(req_valid), .O_req_ready(ready_b),
    .I_req_wen(req_wen), .I_req_addr(req_addr), .I_req_wdata(req_wdata),
    .I_req_wstrb(req_wstrb), .O_rsp_valid(rsp_valid_b), .I_rsp_ready(rsp_ready),
    .O_rsp_rdata(rdata_b), .O_rsp_err(err_b), .O_mtip(mtip_b), .O_msip(msip_b));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int tx_id = 0;

  // Edge counter: edge n is the n-th edge after reset is released.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference mtime: last written value plus ticks on edges w+1 .. n-1 (tick on edges n % D == 0).
  logic [63:0] mx [2];
  int          mw [2];

  function automatic logic [63:0] mt_before(input int d, input int n);
    int dv;
    dv = (d == 0) ? 1 : 4;
    return mx[d] + 64'((n - 1) / dv - mw[d] / dv);
  endfunction

  function automatic logic [63:0] tb_merge(input logic [63:0] o, input logic [63:0] v,
                                           input logic [7:0] s);
    logic [63:0] m;
    for (int i = 0; i < 64; i++) m[i] = s[i / 8];
    return (o & ~m) | (v & m);
  endfunction

  typedef struct {
    logic [63:0] rd_a;
    logic        err_a;
    logic [63:0] rd_b;
    logic        err_b;
    int          id;
  } exp_t;

  exp_t sb[$];

  // Response monitor: pop one expectation per completed response handshake.
  always @(negedge clk) begin
    if (!rst && rsp_valid_a && rsp_ready) begin
      exp_t e;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got rdata %h want no response", rdata_a);
      end else begin
        e = sb.pop_front();
        chk($sformatf("rsp%0d_rdata_div1", e.id), rdata_a, e.rd_a);
        chk($sformatf("rsp%0d_err_div1", e.id), err_a, e.err_a);
        chk($sformatf("rsp%0d_valid_div4", e.id), rsp_valid_b, 1);
        chk($sformatf("rsp%0d_rdata_div4", e.id), rdata_b, e.rd_b);
        chk($sformatf("rsp%0d_err_div4", e.id), err_b, e.err_b);
      end
    end
  end

  // One request, accepted on the next edge; returns just after that accept edge.
  task automatic send(input logic wen, input logic [31:0] addr, input logic [63:0] wdata,
                      input logic [7:0] strb, input logic [63:0] exp_rd, input logic exp_err,
                      output int n);
    exp_t e;
    @(posedge clk); #1;
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    n = cyc + 1;
    e.id = tx_id; tx_id++;
    e.rd_a = exp_rd; e.rd_b = exp_rd; e.err_a = exp_err; e.err_b = exp_err;
    if (!exp_err && addr == A_MTIME) begin
      if (!wen) begin
        e.rd_a = mt_before(0, n);
        e.rd_b = mt_before(1, n);
      end else if (strb != 8'd0) begin
        for (int d = 0; d < 2; d++) begin
          mx[d] = tb_merge(mt_before(d, n), wdata, strb);
          mw[d] = n;
        end
      end
    end
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0; req_wen = 1'b0; req_wstrb = 8'd0;
  endtask

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
    logic [63:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vt [18];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want test end");
    $fatal(1);
  end

  initial begin
    int n;
    int w;
    int g;
    exp_t e;
    mx[0] = 64'd0; mx[1] = 64'd0; mw[0] = 0; mw[1] = 0;

    vt[0]  = '{1'b0, A_CMP,              64'd0,                  8'h00, ONES,                   1'b0};
    vt[1]  = '{1'b0, A_MSIP,             64'd0,                  8'h00, 64'd0,                  1'b0};
    vt[2]  = '{1'b0, BASE + 32'h4004,    64'd0,                  8'h00, 64'd0,                  1'b1};
    vt[3]  = '{1'b0, BASE + 32'h8000,    64'd0,                  8'h00, 64'd0,                  1'b1};
    vt[4]  = '{1'b1, BASE + 32'h8000,    64'd5,                  8'hFF, 64'd0,                  1'b1};
    vt[5]  = '{1'b1, BASE + 32'h4004,    64'd0,                  8'hFF, 64'd0,                  1'b1};
    vt[6]  = '{1'b0, A_CMP,              64'd0,                  8'h00, ONES,                   1'b0};
    vt[7]  = '{1'b1, A_CMP,              64'd0,                  8'h00, 64'd0,                  1'b0};
    vt[8]  = '{1'b0, A_CMP,              64'd0,                  8'h00, ONES,                   1'b0};
    vt[9]  = '{1'b1, A_CMP,              64'h0000_0000_1234_5678, 8'h0F, 64'd0,                  1'b0};
    vt[10] = '{1'b0, A_CMP,              64'd0,                  8'h00, 64'hFFFF_FFFF_1234_5678, 1'b0};
    vt[11] = '{1'b1, A_CMP,              ONES,                   8'hFF, 64'd0,                  1'b0};
    vt[12] = '{1'b1, A_MSIP,             64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 64'd0,                  1'b0};
    vt[13] = '{1'b0, A_MSIP,             64'd0,                  8'h00, 64'd0,                  1'b0};
    vt[14] = '{1'b0, BASE + 32'hBFFC,    64'd0,                  8'h00, 64'd0,                  1'b1};
    vt[15] = '{1'b0, BASE + 32'h0008,    64'd0,                  8'h00, 64'd0,                  1'b1};
    vt[16] = '{1'b1, BASE + 32'hBFF9,    64'd0,                  8'hFF, 64'd0,                  1'b1};
    vt[17] = '{1'b0, A_MTIME,            64'd0,                  8'h00, 64'd0,                  1'b0};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid_a, 0);
    chk("rst_rdata", rdata_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_mtip", mtip_a, 0);
    chk("rst_msip", msip_a, 0);
    chk("rst_mtip_div4", mtip_b, 0);
    chk("rst_req_ready", ready_a, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Idle, then read mtime.
    repeat (9) @(posedge clk);
    send(1'b0, A_MTIME, 64'd0, 8'h00, 64'd0, 1'b0, n);
    chk("idle_mtip", mtip_a, 0);

    // Table: decode, errors, strobes, msip.
    for (int i = 0; i < 18; i++) begin
      send(vt[i].wen, vt[i].addr, vt[i].wdata, vt[i].strb, vt[i].exp_rd, vt[i].exp_err, n);
    end
    chk("table_mtip", mtip_a, 0);

    // mtip rises exactly when mtime reaches mtimecmp, clears on a raising write.
    send(1'b1, A_MTIME, 64'd0, 8'hFF, 64'd0, 1'b0, w);
    send(1'b1, A_CMP, 64'd20, 8'hFF, 64'd0, 1'b0, n);
    g = 0;
    while ((cyc - w) < 19 && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("cmp_wait", cyc - w, 19);
    chk("mtip_at_19", mtip_a, 0);
    @(negedge clk);
    chk("mtip_at_20", mtip_a, 1);
    send(1'b1, A_CMP, 64'd1000, 8'hFF, 64'd0, 1'b0, n);
    chk("mtip_cleared", mtip_a, 0);

    // Prescaled count and partial 32-bit write of mtime.
    send(1'b1, A_MTIME, 64'd0, 8'hFF, 64'd0, 1'b0, n);
    repeat (16) @(posedge clk);
    send(1'b0, A_MTIME, 64'd0, 8'h00, 64'd0, 1'b0, n);
    send(1'b1, A_MTIME, 64'h1_0000_0003, 8'hFF, 64'd0, 1'b0, n);
    send(1'b1, A_MTIME, 64'h0000_0000_AAAA_BBBB, 8'h0F, 64'd0, 1'b0, n);
    send(1'b0, A_MTIME, 64'd0, 8'h00, 64'd0, 1'b0, n);

    // Wrap from all-ones; mtip follows the compare without sticking.
    send(1'b1, A_MTIME, ONES, 8'hFF, 64'd0, 1'b0, n);
    chk("wrap_mtip_high", mtip_a, 1);
    @(posedge clk); #1;
    chk("wrap_mtip_low", mtip_a, 0);
    send(1'b0, A_MTIME, 64'd0, 8'h00, 64'd0, 1'b0, n);

    // Backpressure with a second request waiting, then back-to-back release.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_wen = 1'b1; req_addr = A_MSIP; req_wdata = 64'd1; req_wstrb = 8'h01;
    e = '{64'd0, 1'b0, 64'd0, 1'b0, tx_id}; tx_id++;
    sb.push_back(e);
    @(posedge clk); #1;
    req_wen = 1'b0; req_wdata = 64'd0; req_wstrb = 8'h00;
    e = '{64'd1, 1'b0, 64'd1, 1'b0, tx_id}; tx_id++;
    sb.push_back(e);
    repeat (3) begin
      @(negedge clk);
      chk("stall_req_ready", ready_a, 0);
      chk("stall_req_ready_div4", ready_b, 0);
      chk("stall_rsp_valid", rsp_valid_a, 1);
      chk("stall_rdata", rdata_a, 0);
      chk("stall_msip", msip_a, 1);
      chk("stall_msip_div4", msip_b, 1);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b_rsp_valid", rsp_valid_a, 1);

    // Reset with a response still pending discards it.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = A_MSIP;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("pend_rsp_valid", rsp_valid_a, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    chk("midrst_rsp_valid", rsp_valid_a, 0);
    chk("midrst_rdata", rdata_a, 0);
    chk("midrst_msip", msip_a, 0);

    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_040750_clint.md
Name: ysyx_040750_clint

Overview:
Core-local interruptor sitting directly upstream of the CSR file. Owns memory-mapped mtime, mtimecmp and msip registers behind the LSU MMIO port, and produces the machine timer-pending level that drives the CSR file's mtip input (mip[7]). Also exports a software-interrupt level for a future msip path.

Parameters:
BASE_ADDR, 32'h0200_0000, base of the CLINT window; offsets below are relative to it.
TICK_DIV, 1, core clocks per mtime increment; legal range 1..65535.
MTIMECMP_RST, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp, so no timer interrupt fires out of reset.

Ports:
I_sys_clk  in  1  core clock
I_rst  in  1  reset
I_req_valid  in  1  MMIO request valid from LSU
O_req_ready  out  1  request accepted when valid & ready
I_req_wen  in  1  1 = write, 0 = read
I_req_addr  in  32  byte address
I_req_wdata  in  64  write data, lane-aligned
I_req_wstrb  in  8  byte enables for writes
O_rsp_valid  out  1  response valid
I_rsp_ready  in  1  LSU accepts response
O_rsp_rdata  out  64  read data; 0 for writes and errors
O_rsp_err  out  1  access fault: unmapped or misaligned
O_mtip  out  1  timer pending, to CSR file mtip input
O_msip  out  1  software pending level, msip[0]

Behaviour:
- Synchronous active-high reset: mtime=0, mtimecmp=MTIMECMP_RST, msip=0, prescaler=0, O_mtip=0, O_msip=0, O_rsp_valid=0, O_rsp_rdata=0, O_rsp_err=0.
- Register map, offsets from BASE_ADDR: 0x0000 msip (bit 0 writable, bits 63:1 read 0); 0x4000 mtimecmp (64b); 0xBFF8 mtime (64b). Any other address is unmapped.
- Handshake:
  - At most one outstanding response. O_req_ready = ~O_rsp_valid | I_rsp_ready.
  - An accepted request produces O_rsp_valid on the next edge, giving 1-cycle latency.
  - The response holds stable until I_rsp_ready is sampled high. O_rsp_valid drops on that edge unless a new request is accepted in the same cycle, which is back-to-back at full rate.
- Reads:
  - Return the full 64-bit register value as of the accept edge.
  - A read of mtime returns its pre-increment value if a tick coincides.
- Writes:
  - Byte-merged per I_req_wstrb; wstrb=0 is a legal no-op with an OK response.
  - A partial write to mtime or mtimecmp updates only the strobed bytes. This supports 32-bit software sequences.
- Error cases:
  - addr[2:0]!=0, or an unmapped offset, gives O_rsp_err=1 and rdata=0.
  - No state changes on an error access.
- Prescaler:
  - Counts 0..TICK_DIV-1. mtime increments by 1 on the edge where the prescaler equals TICK_DIV-1, and the prescaler returns to 0.
  - With TICK_DIV=1, mtime increments every cycle.
  - mtime wraps from 2^64-1 to 0.
- Collision: an mtime write wins over a tick in the same cycle; strobed bytes take the written value and unstrobed bytes keep the old value without the increment. The prescaler is not reset by the write.
- O_mtip is registered from the post-edge values: O_mtip = (mtime_next >= mtimecmp_next), unsigned 64-bit compare. A write making mtimecmp <= mtime raises O_mtip on the same edge that commits the write. Writing mtimecmp above mtime clears it on that edge. It is a level, not sticky.
- O_msip = msip[0], registered.
- A reset mid-transaction discards the pending response; the LSU must not expect it.

Decomposition:
- Shared package: CLINT offsets (MSIP_OFF, MTIMECMP_OFF, MTIME_OFF), BASE_ADDR default, and the byte-merge function (64b old, 64b new, 8b strb).
- Sub-module ysyx_040750_clint_timer: prescaler + mtime counter with a strobed write port. The top holds decode, mtimecmp, msip, the compare and the response register.

Test Plan:
- Reset, then idle 10 cycles with TICK_DIV=1 -> read mtime returns 9 or 10 per accept edge, O_mtip=0, mtimecmp reads 64'hFFFF_FFFF_FFFF_FFFF.
- Write mtimecmp=20 while mtime=5 -> O_mtip rises on the edge where mtime_next=20; then write mtimecmp=1000 -> O_mtip=0 on the commit edge.
- TICK_DIV=4: write mtime=0, then wait 16 cycles -> mtime=4; write wstrb=8'h0F data 0xAAAA_BBBB to mtime=0x1_0000_0003 -> reads 0x1_AAAA_BBBB.
- Write mtime=64'hFFFF_FFFF_FFFF_FFFF, TICK_DIV=1 -> next read returns 0 or 1; O_mtip follows the compare without sticking.
- Read at BASE+0x4004 (misaligned) and BASE+0x8000 (unmapped) -> O_rsp_err=1, rdata=0, no register change.
- I_rsp_ready held low 3 cycles with a second request pending -> O_req_ready=0, response stable; release -> back-to-back responses, msip write 1 gives O_msip=1.
